// File: rtl/alzette_iter_unit_if.sv
// Request/response bundle for alzette_iter_unit: valid/ready request side carrying
// (x, y, c, dec) lanes and valid/ready result side carrying (x, y) lanes.
interface alzette_iter_unit_if #(
  parameter int unsigned LANES = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_dec;
  logic [32*LANES-1:0]   in_x;
  logic [32*LANES-1:0]   in_y;
  logic [32*LANES-1:0]   in_c;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*LANES-1:0]   out_x;
  logic [32*LANES-1:0]   out_y;
  logic                  busy;

  modport master (
    output in_valid, in_dec, in_x, in_y, in_c, out_ready,
    input  in_ready, out_valid, out_x, out_y, busy
  );

  modport slave (
    input  in_valid, in_dec, in_x, in_y, in_c, out_ready,
    output in_ready, out_valid, out_x, out_y, busy
  );
endinterface

// File: rtl/alzette_iter_unit.sv
// Iterative multi-lane Alzette / inverse-Alzette engine, STEPS_PER_CYCLE steps per clock.
// Optional flush input enabled by defining ALZETTE_ITER_FLUSH_EN.
module alzette_iter_unit #(
  parameter int unsigned LANES           = 1,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst,
`ifdef ALZETTE_ITER_FLUSH_EN
  input logic flush,
`endif
  alzette_iter_unit_if.slave bus
);

  localparam int unsigned W = 32 * LANES;

  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4) ||
      LANES < 1 || LANES > 4) begin : g_bad_cfg
    $fatal(1, "alzette_iter_unit: illegal LANES or STEPS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e         r_state;
  state_e         w_state_next;
  logic [W-1:0]   r_x, r_y, r_c;
  logic           r_dec;
  logic [1:0]     r_cnt;
  logic [W-1:0]   r_out_x, r_out_y;
  logic [W-1:0]   w_nx, w_ny;
  logic [1:0]     w_cnt_next;
  logic           w_last;
  logic           w_in_ready;
  logic           w_accept;
  logic           w_load_out;
  logic           w_flush;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [4:0] rot_r(input logic [1:0] k);
    case (k)
      2'd0:    return 5'd31;
      2'd1:    return 5'd17;
      2'd2:    return 5'd0;
      default: return 5'd24;
    endcase
  endfunction

  function automatic logic [4:0] rot_s(input logic [1:0] k);
    case (k)
      2'd0:    return 5'd24;
      2'd1:    return 5'd17;
      2'd2:    return 5'd31;
      default: return 5'd16;
    endcase
  endfunction

  // One cycle's worth of chained steps for a single lane, starting at step k0.
  function automatic logic [63:0] step_group(input logic [31:0] x_in, input logic [31:0] y_in,
                                             input logic [31:0] c, input logic [1:0] k0,
                                             input logic dec);
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  k;
    x = x_in;
    y = y_in;
    k = k0;
    for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
      if (dec) begin
        x = x ^ c;
        y = y ^ ror32(x, rot_s(k));
        x = x - ror32(y, rot_r(k));
        k = k - 2'd1;
      end else begin
        x = x + ror32(y, rot_r(k));
        y = y ^ ror32(x, rot_s(k));
        x = x ^ c;
        k = k + 2'd1;
      end
    end
    return {x, y};
  endfunction

  always_comb begin
    w_nx = '0;
    w_ny = '0;
    for (int l = 0; l < LANES; l++) begin
      {w_nx[32*l +: 32], w_ny[32*l +: 32]} =
          step_group(r_x[32*l +: 32], r_y[32*l +: 32], r_c[32*l +: 32], r_cnt, r_dec);
    end
  end

  // The last group is the one that brings the counter back to its start value.
  assign w_cnt_next = r_dec ? (r_cnt - 2'(STEPS_PER_CYCLE)) : (r_cnt + 2'(STEPS_PER_CYCLE));
  assign w_last     = (w_cnt_next == (r_dec ? 2'd3 : 2'd0));

`ifdef ALZETTE_ITER_FLUSH_EN
  assign w_flush = flush && (r_state != StIdle);
`else
  assign w_flush = 1'b0;
`endif

  assign w_in_ready = ((r_state == StIdle) || (r_state == StDone && bus.out_ready)) && !w_flush;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_state_next = r_state;
    w_load_out   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = StRun;
      end
      StRun: begin
        if (w_last) begin
          w_load_out   = 1'b1;
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) w_state_next = w_accept ? StRun : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    if (w_flush) begin
      w_state_next = StIdle;
      w_load_out   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= '0;
      r_dec   <= 1'b0;
      r_cnt   <= 2'd0;
      r_out_x <= '0;
      r_out_y <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_x   <= bus.in_x;
        r_y   <= bus.in_y;
        r_c   <= bus.in_c;
        r_dec <= bus.in_dec;
        r_cnt <= bus.in_dec ? 2'd3 : 2'd0;
      end else if (r_state == StRun) begin
        r_x   <= w_nx;
        r_y   <= w_ny;
        r_cnt <= w_cnt_next;
      end
      if (w_load_out) begin
        r_out_x <= w_nx;
        r_out_y <= w_ny;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == StDone);
  assign bus.busy      = (r_state != StIdle);
  assign bus.out_x     = r_out_x;
  assign bus.out_y     = r_out_y;

endmodule

// File: tb/tb_alzette_iter_unit.sv
// Self-checking bench for alzette_iter_unit over several LANES / STEPS_PER_CYCLE builds,
// checked against a word-level Alzette reference model.
module tb_alzette_iter_unit;

  localparam int NCFG = 8;
  localparam int CFG_L [NCFG] = '{1, 1, 2, 4, 3, 1, 3, 2};
  localparam int CFG_N [NCFG] = '{1, 4, 2, 1, 2, 2, 4, 1};
  localparam int ROT_R [4] = '{31, 17, 0, 24};
  localparam int ROT_S [4] = '{24, 17, 31, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]   sel     = 3'd0;
  logic         t_valid = 1'b0;
  logic         t_dec   = 1'b0;
  logic         t_ready = 1'b0;
  logic [127:0] t_x = '0, t_y = '0, t_c = '0;
`ifdef ALZETTE_ITER_FLUSH_EN
  logic         t_flush = 1'b0;
`endif

  logic [NCFG-1:0] w_ready, w_valid, w_busy;
  logic [127:0]    w_ox [NCFG];
  logic [127:0]    w_oy [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned L = CFG_L[g];
    localparam int unsigned N = CFG_N[g];
    alzette_iter_unit_if #(.LANES(L)) bus ();
    assign bus.in_valid  = t_valid && (sel == g);
    assign bus.in_dec    = t_dec;
    assign bus.in_x      = t_x[32*L-1:0];
    assign bus.in_y      = t_y[32*L-1:0];
    assign bus.in_c      = t_c[32*L-1:0];
    assign bus.out_ready = t_ready && (sel == g);
    assign w_ready[g]    = bus.in_ready;
    assign w_valid[g]    = bus.out_valid;
    assign w_busy[g]     = bus.busy;
    assign w_ox[g]       = 128'(bus.out_x);
    assign w_oy[g]       = 128'(bus.out_y);
    alzette_iter_unit #(.LANES(L), .STEPS_PER_CYCLE(N)) u_dut (
      .clk  (clk),
      .rst  (rst),
`ifdef ALZETTE_ITER_FLUSH_EN
      .flush(t_flush && (sel == g)),
`endif
      .bus  (bus)
    );
  end

  logic         m_ready, m_valid, m_busy;
  logic [127:0] m_ox, m_oy;
  always_comb begin
    m_ready = w_ready[sel];
    m_valid = w_valid[sel];
    m_busy  = w_busy[sel];
    m_ox    = w_ox[sel];
    m_oy    = w_oy[sel];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cfg=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] v, input int n);
    return (n == 0) ? v : ((v >> n) | (v << (32 - n)));
  endfunction

  function automatic void alz_ref(input int lanes, input logic dec, input logic [127:0] x,
                                  input logic [127:0] y, input logic [127:0] c,
                                  output logic [127:0] ox, output logic [127:0] oy);
    ox = '0;
    oy = '0;
    for (int l = 0; l < lanes; l++) begin
      logic [31:0] a, b, k;
      a = x[32*l +: 32];
      b = y[32*l +: 32];
      k = c[32*l +: 32];
      for (int i = 0; i < 4; i++) begin
        int j;
        j = dec ? 3 - i : i;
        if (!dec) begin
          a = a + ror(b, ROT_R[j]);
          b = b ^ ror(a, ROT_S[j]);
          a = a ^ k;
        end else begin
          a = a ^ k;
          b = b ^ ror(a, ROT_S[j]);
          a = a - ror(b, ROT_R[j]);
        end
      end
      ox[32*l +: 32] = a;
      oy[32*l +: 32] = b;
    end
  endfunction

  function automatic logic [127:0] lane_mask(input int lanes);
    logic [127:0] m;
    m = '0;
    for (int l = 0; l < lanes; l++) m[32*l +: 32] = 32'hffff_ffff;
    return m;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic dec, input logic [127:0] x, input logic [127:0] y,
                          input logic [127:0] c);
    int n;
    n = 0;
    while (!m_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", 128'(m_ready), 128'd1);
    t_dec   = dec;
    t_x     = x;
    t_y     = y;
    t_c     = c;
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!m_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic dec, input logic [127:0] x,
                        input logic [127:0] y, input logic [127:0] c,
                        output logic [127:0] ox, output logic [127:0] oy);
    int           lat;
    logic [127:0] ex, ey;
    alz_ref(CFG_L[sel], dec, x, y, c, ex, ey);
    start_op(dec, x, y, c);
    wait_result(lat);
    check({tag, "_lat"}, 128'(lat), 128'(4 / CFG_N[sel]));
    check({tag, "_x"}, m_ox, ex);
    check({tag, "_y"}, m_oy, ey);
    ox = m_ox;
    oy = m_oy;
    t_ready = 1'b1;
    tick();
    t_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] ox, oy, x, y, c, ex, ey, x2, y2, c2, prev_x;
    int           lat, seen;

    tick();
    tick();
    rst = 1'b0;

    // Reset state of every build.
    for (int g = 0; g < NCFG; g++) begin
      sel = 3'(g);
      #0;
      check("rst_valid", 128'(m_valid), 128'd0);
      check("rst_ready", 128'(m_ready), 128'd1);
      check("rst_busy", 128'(m_busy), 128'd0);
      check("rst_ox", m_ox, 128'd0);
      check("rst_oy", m_oy, 128'd0);
    end

    // Single-lane encryption, one step per cycle, hand-derived vector.
    sel = 3'd0;
    run_op("s1", 1'b0, 128'd0, 128'd0, 128'd1, ox, oy);
    check("s1_ox_const", ox, 128'h0180_8000);
    check("s1_oy_const", oy, 128'h8000_8180);

    // Full inverse in a single cycle.
    sel = 3'd1;
    run_op("s2", 1'b1, 128'h0180_8000, 128'h8000_8180, 128'd1, ox, oy);
    check("s2_ox_const", ox, 128'd0);
    check("s2_oy_const", oy, 128'd0);

    // Two lanes, two steps per cycle, no carry between lanes.
    sel = 3'd2;
    run_op("s3", 1'b0, 128'd0, 128'd0, 128'd1, ox, oy);
    check("s3_ox_const", ox, 128'h0000_0000_0180_8000);
    check("s3_oy_const", oy, 128'h0000_0000_8000_8180);

    // Backpressure with ignored requests, then back-to-back accept on release.
    sel = 3'd0;
    x = rnd128(); y = rnd128(); c = rnd128();
    alz_ref(1, 1'b0, x, y, c, ex, ey);
    start_op(1'b0, x, y, c);
    check("s4_busy_run", 128'(m_busy), 128'd1);
    wait_result(lat);
    check("s4_lat", 128'(lat), 128'd4);
    t_valid = 1'b1;
    t_dec   = 1'b1;
    t_x     = rnd128();
    t_y     = rnd128();
    for (int i = 0; i < 5; i++) begin
      check("s4_hold_valid", 128'(m_valid), 128'd1);
      check("s4_hold_ready", 128'(m_ready), 128'd0);
      check("s4_hold_ox", m_ox, ex);
      check("s4_hold_oy", m_oy, ey);
      tick();
    end
    x2 = rnd128(); y2 = rnd128(); c2 = rnd128();
    t_dec   = 1'b0;
    t_x     = x2;
    t_y     = y2;
    t_c     = c2;
    t_ready = 1'b1;
    #0;
    check("s4_release_ready", 128'(m_ready), 128'd1);
    tick();
    t_valid = 1'b0;
    t_ready = 1'b0;
    alz_ref(1, 1'b0, x2, y2, c2, ex, ey);
    wait_result(lat);
    check("s4_b2b_lat", 128'(lat), 128'd4);
    check("s4_b2b_ox", m_ox, ex);
    check("s4_b2b_oy", m_oy, ey);
    t_ready = 1'b1;
    tick();
    t_ready = 1'b0;

    // Reset the cycle after an accept aborts the operation.
    start_op(1'b0, rnd128(), rnd128(), rnd128());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_valid", 128'(m_valid), 128'd0);
    check("s5_ox", m_ox, 128'd0);
    check("s5_oy", m_oy, 128'd0);
    check("s5_ready", 128'(m_ready), 128'd1);
    check("s5_busy", 128'(m_busy), 128'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) seen++;
      tick();
    end
    check("s5_no_result", 128'(seen), 128'd0);

    // Random encrypt/decrypt round trips across every build.
    for (int i = 0; i < 1000; i++) begin
      sel = 3'(i % NCFG);
      x = rnd128(); y = rnd128(); c = rnd128();
      run_op("rnd_enc", 1'b0, x, y, c, ox, oy);
      run_op("rnd_dec", 1'b1, ox, oy, c, ex, ey);
      check("rnd_rt_x", ex, x & lane_mask(CFG_L[sel]));
      check("rnd_rt_y", ey, y & lane_mask(CFG_L[sel]));
    end

`ifdef ALZETTE_ITER_FLUSH_EN
    // Flush in RUN discards the operation and keeps the previous result.
    sel = 3'd0;
    prev_x = m_ox;
    start_op(1'b0, rnd128(), rnd128(), rnd128());
    tick();
    t_flush = 1'b1;
    tick();
    t_flush = 1'b0;
    check("fl_run_valid", 128'(m_valid), 128'd0);
    check("fl_run_busy", 128'(m_busy), 128'd0);
    check("fl_run_ready", 128'(m_ready), 128'd1);
    check("fl_run_ox", m_ox, prev_x);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) seen++;
      tick();
    end
    check("fl_run_no_result", 128'(seen), 128'd0);

    // Flush in DONE wins over the handshake and a pending request.
    x = rnd128(); y = rnd128(); c = rnd128();
    alz_ref(1, 1'b0, x, y, c, ex, ey);
    start_op(1'b0, x, y, c);
    wait_result(lat);
    t_flush = 1'b1;
    t_ready = 1'b1;
    t_valid = 1'b1;
    tick();
    t_flush = 1'b0;
    t_ready = 1'b0;
    t_valid = 1'b0;
    check("fl_done_busy", 128'(m_busy), 128'd0);
    check("fl_done_valid", 128'(m_valid), 128'd0);
    check("fl_done_ox", m_ox, ex);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
